// File: rtl/fetch_unit_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : fetch_unit_if
// Purpose  : Instruction-memory request/response bus plus the decode-side
//            instruction-register handshake of the fetch stage.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface fetch_unit_if #(
   parameter int PC_W    = 64,
   parameter int INSTR_W = 32
);
   logic               imem_req;
   logic [PC_W-1:0]    imem_addr;
   logic               imem_ack;
   logic               imem_rvalid;
   logic [INSTR_W-1:0] imem_rdata;

   logic               ir_valid;
   logic [INSTR_W-1:0] ir_instr;
   logic [PC_W-1:0]    ir_pc;
   logic               ir_ready;

   modport master (
      output imem_req, imem_addr,
      input  imem_ack, imem_rvalid, imem_rdata,
      output ir_valid, ir_instr, ir_pc,
      input  ir_ready
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_ack, imem_rvalid, imem_rdata,
      input  ir_valid, ir_instr, ir_pc,
      output ir_ready
   );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : fetch_unit
// Purpose  : Single-outstanding instruction fetcher with PC-advance strobe and
//            a small instruction FIFO toward decode; flush drops everything.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module fetch_unit #(
   parameter int PC_W    = 64,
   parameter int INSTR_W = 32,
   parameter int DEPTH   = 2
) (
   input  wire logic                   clock,
   input  wire logic                   reset,
   input  wire logic [PC_W-1:0]        pc,
   input  wire logic                   fetch_en,
   input  wire logic                   flush,
   output logic                        pc_advance,
   output logic [$clog2(DEPTH):0]      count,
   fetch_unit_if.master                bus
);
   localparam int c_PTR_W = $clog2(DEPTH);
   localparam logic [c_PTR_W:0] c_DEPTH = (c_PTR_W + 1)'(DEPTH);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_REQ   = 2'd1;
   localparam logic [1:0] c_WAIT  = 2'd2;
   localparam logic [1:0] c_DRAIN = 2'd3;

   logic [1:0]         r_state;
   logic [1:0]         w_state_nxt;
   logic [PC_W-1:0]    r_addr;
   logic               r_pc_advance;

   logic [INSTR_W-1:0] r_instr_mem [DEPTH];
   logic [PC_W-1:0]    r_pc_mem    [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_PTR_W:0]   r_count;

   logic w_full;
   logic w_issue;
   logic w_advance;
   logic w_push;
   logic w_pop;

   assign w_full = (r_count == c_DEPTH);

   always_ff @(posedge clock) begin
      if (reset) r_state <= c_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE:  if (fetch_en && !flush && !w_full) w_state_nxt = c_REQ;
         c_REQ: begin
            if (bus.imem_ack)  w_state_nxt = flush ? c_DRAIN : c_WAIT;
            else if (flush)    w_state_nxt = c_IDLE;
         end
         c_WAIT: begin
            // A flush coinciding with rvalid simply drops the data.
            if (bus.imem_rvalid) w_state_nxt = c_IDLE;
            else if (flush)      w_state_nxt = c_DRAIN;
         end
         c_DRAIN: if (bus.imem_rvalid) w_state_nxt = c_IDLE;
         default: w_state_nxt = c_IDLE;
      endcase
   end

   always_comb begin
      bus.imem_req = (r_state == c_REQ);
      w_issue      = (r_state == c_IDLE) && fetch_en && !flush && !w_full;
      w_advance    = (r_state == c_REQ)  && bus.imem_ack && !flush;
      w_push       = (r_state == c_WAIT) && bus.imem_rvalid && !flush;
      bus.ir_valid = (r_count != '0);
      w_pop        = bus.ir_valid && bus.ir_ready && !flush;
      bus.ir_instr = bus.ir_valid ? r_instr_mem[r_rd_ptr] : '0;
      bus.ir_pc    = bus.ir_valid ? r_pc_mem[r_rd_ptr]    : '0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_addr       <= '0;
         r_pc_advance <= 1'b0;
      end else begin
         if (w_issue) r_addr <= pc;
         r_pc_advance <= w_advance;
      end
   end

   always_ff @(posedge clock) begin
      if (reset || flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (w_push) begin
         r_instr_mem[r_wr_ptr] <= bus.imem_rdata;
         r_pc_mem[r_wr_ptr]    <= r_addr;
      end
   end

   assign bus.imem_addr = r_addr;
   assign pc_advance    = r_pc_advance;
   assign count         = r_count;
endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit: directed scenarios with
//            literal expectations, then randomized traffic against a model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_fetch_unit;
   localparam int PC_W    = 64;
   localparam int INSTR_W = 32;
   localparam int DEPTH   = 2;

   logic            clock = 1'b0;
   logic            reset;
   logic [PC_W-1:0] pc;
   logic            fetch_en;
   logic            flush;
   logic            pc_advance;
   logic [1:0]      count;

   fetch_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

   fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
      .clock      (clock),
      .reset      (reset),
      .pc         (pc),
      .fetch_en   (fetch_en),
      .flush      (flush),
      .pc_advance (pc_advance),
      .count      (count),
      .bus        (bus)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0]    pc;
   } entry_t;

   // Reference: expected FIFO contents plus the fetch transaction in progress.
   entry_t          q[$];
   bit              m_req, m_adv, m_wait, m_drain;
   logic [PC_W-1:0] m_addr;

   int n_checks = 0;
   int n_fail   = 0;

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endfunction

   function automatic void model_update();
      int     sz;
      bit     pop_e, push_e, adv;
      entry_t e;
      if (reset) begin
         m_req = 0; m_adv = 0; m_wait = 0; m_drain = 0; m_addr = '0;
         q.delete();
         return;
      end
      sz     = q.size();
      pop_e  = (sz != 0) && bus.ir_ready;
      push_e = 0;
      adv    = 0;
      e      = '0;
      if (m_req) begin
         if (bus.imem_ack) begin
            m_req = 0;
            if (flush) m_drain = 1;
            else begin m_wait = 1; adv = 1; end
         end else if (flush) m_req = 0;
      end else if (m_wait) begin
         if (bus.imem_rvalid) begin
            m_wait = 0;
            if (!flush) begin push_e = 1; e.instr = bus.imem_rdata; e.pc = m_addr; end
         end else if (flush) begin
            m_wait = 0; m_drain = 1;
         end
      end else if (m_drain) begin
         if (bus.imem_rvalid) m_drain = 0;
      end else if (fetch_en && !flush && sz < DEPTH) begin
         m_req = 1; m_addr = pc;
      end
      m_adv = adv;
      if (flush) q.delete();
      else begin
         if (pop_e)  void'(q.pop_front());
         if (push_e) q.push_back(e);
      end
   endfunction

   function automatic void compare_all();
      check("imem_req",   64'(bus.imem_req), 64'(m_req));
      check("imem_addr",  bus.imem_addr, m_addr);
      check("pc_advance", 64'(pc_advance), 64'(m_adv));
      check("count",      64'(count), 64'(q.size()));
      check("ir_valid",   64'(bus.ir_valid), 64'(q.size() != 0));
      if (q.size() != 0) begin
         check("ir_instr", 64'(bus.ir_instr), 64'(q[0].instr));
         check("ir_pc",    bus.ir_pc, q[0].pc);
      end
   endfunction

   task automatic step();
      @(posedge clock);
      model_update();
      @(negedge clock);
      compare_all();
   endtask

   task automatic fetch_one(input logic [PC_W-1:0] p, input logic [INSTR_W-1:0] d);
      pc = p; fetch_en = 1; bus.imem_ack = 1;
      step();
      fetch_en = 0;
      step();
      bus.imem_rvalid = 1; bus.imem_rdata = d;
      step();
      bus.imem_rvalid = 0;
   endtask

   initial begin
      reset = 1; pc = '0; fetch_en = 0; flush = 0;
      bus.imem_ack = 0; bus.imem_rvalid = 0; bus.imem_rdata = '0; bus.ir_ready = 0;
      step(); step();
      check("rst_req",   64'(bus.imem_req), 64'd0);
      check("rst_addr",  bus.imem_addr, 64'd0);
      check("rst_adv",   64'(pc_advance), 64'd0);
      check("rst_count", 64'(count), 64'd0);
      check("rst_instr", 64'(bus.ir_instr), 64'd0);
      check("rst_irpc",  bus.ir_pc, 64'd0);

      // Basic fetch of 0xDEADBEEF at PC 0x10
      reset = 0; fetch_en = 1; pc = 64'h10; bus.imem_ack = 1;
      step();
      check("t1_req",  64'(bus.imem_req), 64'd1);
      check("t1_addr", bus.imem_addr, 64'h10);
      fetch_en = 0;
      step();
      check("t1_adv",  64'(pc_advance), 64'd1);
      check("t1_req0", 64'(bus.imem_req), 64'd0);
      bus.imem_rvalid = 1; bus.imem_rdata = 32'hDEADBEEF;
      step();
      bus.imem_rvalid = 0;
      check("t1_valid", 64'(bus.ir_valid), 64'd1);
      check("t1_instr", 64'(bus.ir_instr), 64'hDEADBEEF);
      check("t1_irpc",  bus.ir_pc, 64'h10);
      check("t1_count", 64'(count), 64'd1);
      check("t1_adv0",  64'(pc_advance), 64'd0);

      // Fill to DEPTH, confirm stall, then drain in order
      reset = 1; step(); reset = 0;
      bus.ir_ready = 0;
      fetch_one(64'h0, 32'hA0A0A0A0);
      fetch_one(64'h1, 32'hA1A1A1A1);
      check("t2_count", 64'(count), 64'd2);
      pc = 64'h2; fetch_en = 1; bus.imem_ack = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("t2_noreq", 64'(bus.imem_req), 64'd0);
      end
      check("t2_head0", bus.ir_pc, 64'h0);
      bus.ir_ready = 1;
      step();
      check("t2_head1", bus.ir_pc, 64'h1);
      check("t2_cnt1",  64'(count), 64'd1);
      step();
      check("t2_cnt0",  64'(count), 64'd0);
      check("t2_req",   64'(bus.imem_req), 64'd1);
      check("t2_addr",  bus.imem_addr, 64'h2);
      fetch_en = 0; bus.imem_ack = 1;
      step();
      bus.imem_rvalid = 1; bus.imem_rdata = 32'h22222222;
      step();
      bus.imem_rvalid = 0;
      step();

      // Slow ack: request held stable for 4 cycles
      pc = 64'h40; fetch_en = 1; bus.imem_ack = 0;
      step();
      fetch_en = 0; pc = 64'h41;
      for (int i = 0; i < 4; i++) begin
         step();
         check("t3_req",  64'(bus.imem_req), 64'd1);
         check("t3_addr", bus.imem_addr, 64'h40);
         check("t3_adv",  64'(pc_advance), 64'd0);
      end
      bus.imem_ack = 1;
      step();
      check("t3_adv1", 64'(pc_advance), 64'd1);
      bus.imem_ack = 0; bus.imem_rvalid = 1; bus.imem_rdata = 32'h40404040;
      step();
      bus.imem_rvalid = 0;
      step();

      // Flush in WAIT discards the following response
      pc = 64'h50; fetch_en = 1; bus.imem_ack = 1;
      step();
      fetch_en = 0;
      step();
      flush = 1;
      step();
      flush = 0; bus.imem_rvalid = 1; bus.imem_rdata = 32'h1234;
      step();
      bus.imem_rvalid = 0;
      check("t4_count", 64'(count), 64'd0);
      check("t4_valid", 64'(bus.ir_valid), 64'd0);
      pc = 64'h80; fetch_en = 1;
      step();
      check("t4_req",  64'(bus.imem_req), 64'd1);
      check("t4_addr", bus.imem_addr, 64'h80);
      fetch_en = 0;
      step();
      bus.imem_rvalid = 1; bus.imem_rdata = 32'h80808080;
      step();
      bus.imem_rvalid = 0;
      step();

      // Flush together with ack, then flush a full FIFO
      pc = 64'h90; fetch_en = 1; bus.imem_ack = 0;
      step();
      fetch_en = 0; bus.imem_ack = 1; flush = 1;
      step();
      check("t5_adv", 64'(pc_advance), 64'd0);
      check("t5_req", 64'(bus.imem_req), 64'd0);
      flush = 0; bus.imem_ack = 0; bus.imem_rvalid = 1; bus.imem_rdata = 32'h5555;
      step();
      bus.imem_rvalid = 0;
      check("t5_count", 64'(count), 64'd0);
      bus.ir_ready = 0;
      fetch_one(64'h100, 32'h01000100);
      fetch_one(64'h101, 32'h01010101);
      check("t5_full", 64'(count), 64'd2);
      flush = 1;
      step();
      flush = 0;
      check("t5_fvalid", 64'(bus.ir_valid), 64'd0);
      check("t5_fcount", 64'(count), 64'd0);

      // Reset in WAIT, stale response ignored
      fetch_one(64'hA0, 32'hA0A0);
      pc = 64'hA1; fetch_en = 1; bus.imem_ack = 1;
      step();
      fetch_en = 0;
      step();
      reset = 1;
      step();
      reset = 0; bus.imem_rvalid = 1; bus.imem_rdata = 32'hBAD;
      step();
      bus.imem_rvalid = 0;
      check("t6_req",   64'(bus.imem_req), 64'd0);
      check("t6_addr",  bus.imem_addr, 64'd0);
      check("t6_adv",   64'(pc_advance), 64'd0);
      check("t6_count", 64'(count), 64'd0);
      check("t6_valid", 64'(bus.ir_valid), 64'd0);
      check("t6_instr", 64'(bus.ir_instr), 64'd0);
      check("t6_irpc",  bus.ir_pc, 64'd0);

      // Simultaneous push and pop at count 1
      fetch_one(64'hB0, 32'hB0B0B0B0);
      pc = 64'hB1; fetch_en = 1; bus.imem_ack = 1;
      step();
      fetch_en = 0;
      step();
      bus.imem_rvalid = 1; bus.imem_rdata = 32'hB1B1B1B1; bus.ir_ready = 1;
      step();
      bus.imem_rvalid = 0;
      check("t6_pp_count", 64'(count), 64'd1);
      check("t6_pp_irpc",  bus.ir_pc, 64'hB1);
      check("t6_pp_instr", 64'(bus.ir_instr), 64'hB1B1B1B1);
      step();

      // Randomized traffic checked every cycle against the model
      for (int cyc = 0; cyc < 3000; cyc++) begin
         reset           = ($urandom_range(0, 199) == 0);
         flush           = ($urandom_range(0, 15) == 0);
         fetch_en        = ($urandom_range(0, 3) != 0);
         bus.ir_ready    = ($urandom_range(0, 1) == 1);
         bus.imem_ack    = ($urandom_range(0, 1) == 1);
         bus.imem_rvalid = (m_wait || m_drain) ? ($urandom_range(0, 1) == 1)
                                               : ($urandom_range(0, 7) == 0);
         bus.imem_rdata  = $urandom;
         if (flush || $urandom_range(0, 31) == 0) pc = {$urandom, $urandom};
         else if (m_adv)                          pc = pc + 64'd1;
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage directly downstream of the program counter. Takes the current PC and issues one word-addressed request at a time to instruction memory. Returns the PC-advance strobe that drives the counter's increment select, and buffers fetched instructions with their PCs in a small FIFO for the decode stage. A flush discards buffered and in-flight instructions on branch redirect.

Parameters:
PC_W, 64, width of PC and instruction address (word-addressed; PC steps by 1)
INSTR_W, 32, instruction word width
DEPTH, 2, instruction FIFO entries (power of two, >= 2)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
pc  in  PC_W  current PC from program counter
fetch_en  in  1  permit new fetch requests
flush  in  1  redirect: drop buffered and in-flight instructions
imem_req  out  1  memory request valid
imem_addr  out  PC_W  request address (latched PC)
imem_ack  in  1  memory accepted request this cycle
imem_rvalid  in  1  read data valid
imem_rdata  in  INSTR_W  read data
pc_advance  out  1  one-cycle strobe; upstream maps it to increment select (01)
ir_valid  out  1  FIFO head valid
ir_instr  out  INSTR_W  head instruction
ir_pc  out  PC_W  PC of head instruction
ir_ready  in  1  decode accepts head this cycle
count  out  log2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset is synchronous: it is sampled only at the rising edge of clock. It forces state IDLE, FIFO empty, and count=0. It clears imem_req, imem_addr, pc_advance, ir_valid, ir_instr, and ir_pc to 0. Reset wins over all other inputs. A response arriving after reset is ignored (IDLE ignores rvalid).
- FSM states: IDLE, REQ, WAIT, DRAIN. At most one request is outstanding.
- IDLE: if fetch_en=1, flush=0 and count<DEPTH, latch pc into imem_addr and go to REQ. Otherwise stay in IDLE.
- REQ: imem_req=1, and imem_addr is held stable until imem_ack. On ack: go to WAIT, and pc_advance=1 in the next cycle for exactly one cycle.
- WAIT: on imem_rvalid, push {imem_rdata, imem_addr} into the FIFO and go to IDLE. Minimum issue interval is 3 cycles, which guarantees the PC has advanced before the next latch.
- DRAIN: the next imem_rvalid is discarded (no push), then go to IDLE. fetch_en is ignored in DRAIN.
- imem_rvalid in IDLE, REQ or DRAIN-after-discard is ignored.
- FIFO: head is driven on ir_*. Pop occurs when ir_valid && ir_ready. Push and pop in the same cycle are both performed and count is unchanged. Entry order is strict FIFO; pointers wrap mod DEPTH.
- Overflow is impossible by construction: issue requires count<DEPTH, and only one request is outstanding.
- ir_instr/ir_pc: 0 after reset. When ir_valid=0 they are don't-care, and the bench checks them only when valid.
- flush (synchronous, takes priority over push/pop):
  - FIFO is emptied at that edge (count=0, ir_valid=0 next cycle).
  - REQ without ack: drop imem_req, go to IDLE, no pc_advance.
  - REQ with ack in the same cycle: go to DRAIN, no pc_advance.
  - WAIT without rvalid: go to DRAIN.
  - WAIT with rvalid in the same cycle: data is discarded, go to IDLE.
  - A pc_advance already asserted in the flush cycle is not retracted; upstream redirect (select 10) overrides it.
  - In IDLE, no request is issued that cycle.
- count == number of valid FIFO entries. ir_valid == (count != 0).

Test Plan:
- Reset then fetch_en=1, pc=0x10, ack immediate, rvalid one cycle later with 0xDEADBEEF. Required: imem_req for one cycle with addr 0x10, then pc_advance pulse, then ir_valid=1 with ir_instr=0xDEADBEEF and ir_pc=0x10, count=1.
- ir_ready=0, fetch PCs 0x0 and 0x1. Required: count=2, no further imem_req while full. Raise ir_ready: entries pop in order 0x0 then 0x1, and fetching resumes at the next PC.
- Hold imem_ack low 4 cycles in REQ. Required: imem_req and imem_addr stable throughout, pc_advance only after ack.
- Flush while in WAIT, then rvalid with 0x1234. Required: 0x1234 not pushed, count=0, state returns to IDLE; next fetch uses the new pc=0x80.
- Flush in the same cycle as imem_ack. Required: no pc_advance, DRAIN discards the following response. Separately, flush with count=2: ir_valid=0 the next cycle.
- Reset asserted in WAIT, then stale rvalid. Required: all outputs 0, FIFO empty, stale data ignored. Simultaneous push/pop at count=1 keeps count=1.
